// File: rtl/sobel_frame_ctrl_if.sv
// Configuration register port between the pixel source / config master and
// the Sobel frame controller. One write strobe per cycle, registered read data.
interface sobel_frame_ctrl_if;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame controller: generates the video raster (x, y, vde, syncs), the
// line-buffer rotate strobe and a frame-start pulse, and holds the runtime
// configuration (thresh, overlay_on) so it only changes at frame boundaries.
module sobel_frame_ctrl #(
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33,
    parameter logic [7:0] THRESH_RST = 8'd32,
    parameter logic       RUN_RST    = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    sobel_frame_ctrl_if.slave   cfg,
    output logic [9:0]          x,
    output logic [9:0]          y,
    output logic                vde,
    output logic                hsync,
    output logic                vsync,
    output logic                end_of_line,
    output logic                frame_start,
    output logic [7:0]          thresh,
    output logic                overlay_on
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Raster boundaries as 10-bit constants so every compare is width-matched.
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t     state;
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    logic       run_q;
    logic [7:0] thresh_stg;
    logic       overlay_stg;

    logic       active;
    logic       h_last;
    logic       v_last;
    logic       frame_wrap;
    logic       fs_next;
    logic       copy_cfg;
    logic       pending;

    // Frame-level decode of the current counter/state values.
    always_comb begin
        active     = (state != IDLE);
        h_last     = (hcnt == H_LAST);
        v_last     = (vcnt == V_LAST);
        frame_wrap = h_last && v_last;
        // The edge that registers frame_start is the edge that loads the live
        // configuration, so both become visible in the same cycle.
        fs_next    = active && (hcnt == '0) && (vcnt == '0);
        copy_cfg   = (state == IDLE) || fs_next;
        pending    = (thresh_stg != thresh) || (overlay_stg != overlay_on);
    end

    // Sequencer: run/stop state, raster counters and registered raster outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            x           <= '0;
            y           <= '0;
            vde         <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            end_of_line <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every output below
            // decodes the pre-edge hcnt/vcnt/state, giving a uniform 1-cycle lag.
            x           <= active ? hcnt : '0;
            y           <= active ? vcnt : '0;
            vde         <= active && (hcnt < H_ACT) && (vcnt < V_ACT);
            hsync       <= !(active && (hcnt >= HS_BEG) && (hcnt < HS_END));
            vsync       <= !(active && (vcnt >= VS_BEG) && (vcnt < VS_END));
            end_of_line <= active && h_last && (vcnt < V_ACT);
            frame_start <= fs_next;

            if (!active) begin
                hcnt <= '0;
                vcnt <= '0;
            end else if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            case (state)
                IDLE: begin
                    if (run_q) state <= RUN;
                end
                RUN: begin
                    if (!run_q) state <= STOPPING;
                end
                STOPPING: begin
                    // Re-arming before the wrap keeps the raster seamless;
                    // otherwise the frame completes and the raster parks.
                    if (run_q)           state <= RUN;
                    else if (frame_wrap) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register port: staging registers, run bit and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh_stg    <= THRESH_RST;
            overlay_stg   <= 1'b0;
            run_q         <= RUN_RST;
            cfg.cfg_rdata <= '0;
        end else begin
            if (cfg.cfg_we) begin
                case (cfg.cfg_addr)
                    2'd0:    thresh_stg  <= cfg.cfg_wdata;
                    2'd1:    overlay_stg <= cfg.cfg_wdata[0];
                    2'd2:    run_q       <= cfg.cfg_wdata[0];
                    default: ;
                endcase
            end

            // Read data samples the pre-edge registers, so a same-cycle
            // write and read of one address returns the old value.
            case (cfg.cfg_addr)
                2'd0:    cfg.cfg_rdata <= thresh_stg;
                2'd1:    cfg.cfg_rdata <= {7'b0, overlay_stg};
                2'd2:    cfg.cfg_rdata <= {7'b0, run_q};
                default: cfg.cfg_rdata <= {6'b0, pending, active};
            endcase
        end
    end

    // Live configuration: follows staging continuously while idle, otherwise
    // only at the frame_start edge so one frame never mixes two settings.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            thresh     <= THRESH_RST;
            overlay_on <= 1'b0;
        end else if (copy_cfg) begin
            thresh     <= thresh_stg;
            overlay_on <= overlay_stg;
        end
    end

endmodule
